rom_port_arbiter: RTL and testbench

- Shares the single data/write port of the instruction/data ROM between two requesters: M0 (CPU load/store unit) and M1 (debug/program loader).
- Per-cycle round-robin arbitration with single-cycle grant. M1 can lock the port for a burst program load; a lock watchdog bounds the lock.
- Drives `cpu_stall` so the core pipeline freezes while its data request is not granted.
- Sits between the core/loader and the memory's addr/writeEnable/writeData/readData port. The instruction fetch port is untouched.

---
 rtl/rom_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Two-master arbiter for the shared ROM data/write port: round-robin per cycle,
// with an M1 lock mode bounded by a watchdog and a CPU stall output.
module rom_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall,
    output logic          lock_err
);

    localparam int CW = $clog2(LOCK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic SEL_M0 = 1'b0;
    localparam logic SEL_M1 = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [CW-1:0]   r_lock_cnt;
    logic [CW-1:0]   w_lock_cnt_nxt;
    logic            r_relock_blk;
    logic            w_relock_blk_nxt;
    logic            w_timeout;
    logic            r_lock_err;
    logic            r_m0_rvalid;
    logic            r_m1_rvalid;
    logic [DW-1:0]   r_m0_rdata;
    logic [DW-1:0]   r_m1_rdata;
    logic            w_m0_gnt;
    logic            w_m1_gnt;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;

    // Grant selection: round-robin on ties in IDLE, M1-only while locked
    always_comb begin
        w_m0_gnt = 1'b0;
        w_m1_gnt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    if (r_last == SEL_M1) begin
                        w_m0_gnt = 1'b1;
                    end else begin
                        w_m1_gnt = 1'b1;
                    end
                end else if (m0_req) begin
                    w_m0_gnt = 1'b1;
                end else if (m1_req) begin
                    w_m1_gnt = 1'b1;
                end else begin
                    w_m0_gnt = 1'b0;
                    w_m1_gnt = 1'b0;
                end
            end
            ST_LOCK: begin
                w_m1_gnt = m1_req;
            end
            default: begin
                w_m0_gnt = 1'b0;
                w_m1_gnt = 1'b0;
            end
        endcase
    end

    // Memory port mux: idle port is driven to all-zero
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = {AW{1'b0}};
        w_mem_wdata = {DW{1'b0}};
        if (w_m0_gnt) begin
            w_mem_we    = m0_we;
            w_mem_addr  = m0_addr;
            w_mem_wdata = m0_wdata;
        end else if (w_m1_gnt) begin
            w_mem_we    = m1_we;
            w_mem_addr  = m1_addr;
            w_mem_wdata = m1_wdata;
        end else begin
            w_mem_we    = 1'b0;
            w_mem_addr  = {AW{1'b0}};
            w_mem_wdata = {DW{1'b0}};
        end
    end

    // Lock FSM next state and watchdog counter; timeout wins over a voluntary release
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_m1_gnt && m1_lock && !r_relock_blk) begin
                    w_state_nxt    = ST_LOCK;
                    w_lock_cnt_nxt = {CW{1'b0}};
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (r_lock_cnt == CNT_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = {CW{1'b0}};
                    w_timeout      = 1'b1;
                end else if (!m1_lock) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = {CW{1'b0}};
                end else begin
                    w_state_nxt    = ST_LOCK;
                    w_lock_cnt_nxt = r_lock_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = {CW{1'b0}};
            end
        endcase
    end

    // Round-robin pointer and re-lock guard; a forced release hands the next tie to M0
    always_comb begin
        w_last_nxt       = r_last;
        w_relock_blk_nxt = r_relock_blk;
        if (w_timeout) begin
            w_last_nxt = SEL_M1;
        end else if (w_m0_gnt) begin
            w_last_nxt = SEL_M0;
        end else if (w_m1_gnt) begin
            w_last_nxt = SEL_M1;
        end else begin
            w_last_nxt = r_last;
        end
        if (w_timeout) begin
            w_relock_blk_nxt = 1'b1;
        end else if (!m1_lock) begin
            w_relock_blk_nxt = 1'b0;
        end else begin
            w_relock_blk_nxt = r_relock_blk;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last       <= SEL_M1;
            r_lock_cnt   <= {CW{1'b0}};
            r_relock_blk <= 1'b0;
            r_lock_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_relock_blk <= w_relock_blk_nxt;
            if (w_timeout) begin
                r_lock_err <= 1'b1;
            end
        end
    end

    // Read response capture: one rvalid pulse per granted read, data held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= {DW{1'b0}};
            r_m1_rdata  <= {DW{1'b0}};
        end else begin
            r_m0_rvalid <= w_m0_gnt && !m0_we;
            r_m1_rvalid <= w_m1_gnt && !m1_we;
            if (w_m0_gnt && !m0_we) begin
                r_m0_rdata <= mem_rdata;
            end
            if (w_m1_gnt && !m1_we) begin
                r_m1_rdata <= mem_rdata;
            end
        end
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign mem_we    = w_mem_we;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    assign cpu_stall = m0_req && !w_m0_gnt;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign lock_err  = r_lock_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: directed per-cycle vectors push expected
// port values; a negedge monitor pops and compares them and the read responses.
module tb_rom_port_arbiter;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [31:0] Z = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = Z, m0_wdata = Z, m1_addr = Z, m1_wdata = Z, mem_rdata = Z;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, cpu_stall, lock_err;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;

    typedef struct {
        logic        g0, g1, stall, we, rv0, rv1, lerr, zr;
        logic [31:0] addr, wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    exp_t        mon_e;
    logic        prv0 = 1'b0, prv1 = 1'b0, exp_lerr = 1'b0;
    int          total = 0, bad = 0;

    rom_port_arbiter #(.AW(32), .DW(32), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
        end
    endtask

    // One cycle of stimulus plus its hand-computed expected grants
    task automatic step(input logic r,
                        input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic lk, input logic [31:0] mrd,
                        input logic g0, input logic g1, input logic zr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk; mem_rdata = mrd;
        e.g0 = g0; e.g1 = g1; e.stall = q0 && !g0;
        e.we = g0 ? w0 : (g1 ? w1 : 1'b0);
        e.addr = g0 ? a0 : (g1 ? a1 : Z);
        e.wdata = g0 ? d0 : (g1 ? d1 : Z);
        e.rv0 = prv0; e.rv1 = prv1; e.lerr = exp_lerr; e.zr = zr;
        exp_q.push_back(e);
        if (g0 && !w0 && !r) rq0.push_back(mrd);
        if (g1 && !w1 && !r) rq1.push_back(mrd);
        prv0 = g0 && !w0 && !r;
        prv1 = g1 && !w1 && !r;
    endtask

    task automatic idle();
        step(N, N, N, Z, Z, N, N, Z, Z, N, Z, N, N, N);
    endtask

    // Monitor: compare each cycle's expectations and every presented read response
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, mon_e.g0});
            chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, mon_e.g1});
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, mon_e.stall});
            chk("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
            chk("mem_addr", mem_addr, mon_e.addr);
            chk("mem_wdata", mem_wdata, mon_e.wdata);
            chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, mon_e.rv0});
            chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, mon_e.rv1});
            chk("lock_err", {31'd0, lock_err}, {31'd0, mon_e.lerr});
            if (mon_e.zr) begin
                chk("m0_rdata_rst", m0_rdata, Z);
                chk("m1_rdata_rst", m1_rdata, Z);
            end
        end
        if (m0_rvalid === 1'b1) begin
            if (rq0.size() == 0) begin
                total++; bad++;
                $display("FAIL m0_rdata: got unexpected rvalid data %h want none", m0_rdata);
            end else begin
                chk("m0_rdata", m0_rdata, rq0.pop_front());
            end
        end
        if (m1_rvalid === 1'b1) begin
            if (rq1.size() == 0) begin
                total++; bad++;
                $display("FAIL m1_rdata: got unexpected rvalid data %h want none", m1_rdata);
            end else begin
                chk("m1_rdata", m1_rdata, rq1.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // Reset then a lone M0 read
        step(N, N, N, Z, Z, N, N, Z, Z, N, Z, N, N, Y);
        step(N, Y, N, 32'h0000_0010, Z, N, N, Z, Z, N, 32'hDEAD_BEEF, Y, N, N);
        idle();
        // Contention from reset: M0, M1, M0, M1
        step(Y, N, N, Z, Z, N, N, Z, Z, N, Z, N, N, N);
        for (int i = 0; i < 4; i++) begin
            step(N, Y, N, 32'h0000_0100, Z, Y, N, 32'h0000_0200, Z, N, 32'hA5A5_0000 + 32'(i),
                 logic'(i % 2 == 0), logic'(i % 2 == 1), logic'(i == 0));
        end
        idle();
        // Write routing
        step(N, N, N, Z, Z, Y, Y, 32'h0000_0040, 32'h1234_5678, N, Z, N, Y, N);
        idle();
        step(N, Y, Y, 32'h0000_0044, 32'hCAFE_0000, N, N, Z, Z, N, Z, Y, N, N);
        // Lock burst of 8 writes with M0 stalled, then release
        for (int i = 0; i < 8; i++) begin
            step(N, Y, N, 32'h0000_0300, Z, Y, Y, 32'h0000_0080 + 32'(4 * i), 32'h0000_1000 + 32'(i),
                 Y, 32'h7777_0000, N, Y, N);
        end
        step(N, Y, N, 32'h0000_0300, Z, N, N, Z, Z, N, 32'h7777_0000, N, N, N);
        step(N, Y, N, 32'h0000_0300, Z, Y, N, 32'h0000_0204, Z, N, 32'h0BAD_F00D, Y, N, N);
        idle();
        // Watchdog: lock entry then 16 LOCK cycles
        step(N, Y, N, 32'h0000_0304, Z, Y, Y, 32'h0000_0400, 32'hF0F0_0000, Y, Z, N, Y, N);
        for (int i = 0; i < 16; i++) begin
            step(N, Y, N, 32'h0000_0304, Z, Y, Y, 32'h0000_0404 + 32'(4 * i), 32'hF0F0_0001 + 32'(i),
                 Y, Z, N, Y, N);
        end
        exp_lerr = 1'b1;
        step(N, Y, N, 32'h0000_0304, Z, Y, Y, 32'h0000_0500, 32'h0000_0001, Y, 32'h5555_AAAA, Y, N, N);
        step(N, Y, N, 32'h0000_0304, Z, Y, Y, 32'h0000_0504, 32'h0000_0002, Y, Z, N, Y, N);
        step(N, Y, N, 32'h0000_0304, Z, Y, Y, 32'h0000_0504, 32'h0000_0002, Y, 32'h5555_AAAB, Y, N, N);
        step(N, N, N, Z, Z, Y, Y, 32'h0000_0508, 32'h0000_0003, N, Z, N, Y, N);
        step(N, N, N, Z, Z, Y, Y, 32'h0000_050C, 32'h0000_0004, Y, Z, N, Y, N);
        step(N, Y, N, 32'h0000_0600, Z, Y, Y, 32'h0000_0510, 32'h0000_0005, Y, Z, N, Y, N);
        // Reset mid-lock with a granted M1 read pending
        step(Y, Y, N, 32'h0000_0600, Z, Y, N, 32'h0000_0514, Z, Y, 32'h9999_9999, N, Y, N);
        exp_lerr = 1'b0;
        step(N, Y, N, 32'h0000_0600, Z, Y, N, 32'h0000_0514, Z, Y, 32'h1357_9BDF, Y, N, Y);
        idle();
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending exp=%0d rq0=%0d rq1=%0d want 0", exp_q.size(), rq0.size(), rq1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
